// File: rtl/sdpb_pkg.sv
// Shared types and helpers for the simple dual-port RAM controller.
// Holds the clear-engine state encoding, legal read-latency values,
// byte parity and byte-merge helpers used on the read path.
package sdpb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } init_state_t;

  localparam int READ_LAT_1 = 1;
  localparam int READ_LAT_2 = 2;

  // Even parity: stored bit makes the byte plus parity have an even count of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

  // Picks the freshly written byte when forwarded, otherwise the stored byte.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       sel);
    return sel ? new_b : old_b;
  endfunction

endpackage

// File: rtl/sdpb_init_ctrl.sv
// Clear engine: two-state FSM that sweeps INIT_VALUE over the whole array.
// Latency: DEPTH cycles per clear; init_busy drops the cycle after the last write.
// While clearing it owns the write port and user writes are discarded.
module sdpb_init_ctrl
  import sdpb_pkg::*;
#(
  parameter int              DW            = 16,
  parameter int              DEPTH         = 2048,
  parameter int              AW            = 11,
  parameter int              INIT_ON_RESET = 0,
  parameter logic [DW-1:0]   INIT_VALUE    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic [DW/8-1:0]   wr_be,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_data,
  output logic [DW/8-1:0]   mem_be,
  output logic              init_busy
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  init_state_t   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and sweep address; reset restarts any clear from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: start on request, leave after the last address is written.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (init_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) state_d = IDLE;
        else                    cnt_d   = cnt_q + AW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-port mux: the sweep overrides user writes entirely.
  always_comb begin
    mem_we   = wr_en;
    mem_addr = wr_addr;
    mem_data = wr_data;
    mem_be   = wr_be;
    if (state_q == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = cnt_q;
      mem_data = INIT_VALUE;
      mem_be   = '1;
    end
  end

  assign init_busy = (state_q == CLEAR);

endmodule

// File: rtl/sdpb_ram_ctrl.sv
// Simple dual-port RAM with byte enables, collision forwarding and clear engine.
// Latency: READ_LAT (1 or 2) cycles from rd_en to rd_data/rd_valid.
// No backpressure; rd_oce stalls the 2nd output stage, reads ignored while clearing.
// Optional per-byte parity storage and checking under `define SDPB_PARITY_EN.
module sdpb_ram_ctrl
  import sdpb_pkg::*;
#(
  parameter int            DW            = 16,
  parameter int            DEPTH         = 2048,
  parameter int            READ_LAT      = 1,
  parameter int            BYPASS        = 1,
  parameter int            INIT_ON_RESET = 0,
  parameter logic [DW-1:0] INIT_VALUE    = '0,
  localparam int           AW            = $clog2(DEPTH),
  localparam int           NB            = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [NB-1:0] wr_be,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_oce,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_par_err,
  input  logic          init_req,
  output logic          init_busy
);

  // Range limit one bit wider than the address so DEPTH itself is representable.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
`ifdef SDPB_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
`endif

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [NB-1:0] mem_be;

  sdpb_init_ctrl #(
    .DW            (DW),
    .DEPTH         (DEPTH),
    .AW            (AW),
    .INIT_ON_RESET (INIT_ON_RESET),
    .INIT_VALUE    (INIT_VALUE)
  ) u_init (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_be    (mem_be),
    .init_busy (init_busy)
  );

  logic          wr_ok, rd_ok, rd_in_range, coll;
  logic [NB-1:0] fwd_be;
  logic [DW-1:0] rd_word;
  logic          rd_perr;

  assign wr_ok       = mem_we && ({1'b0, mem_addr} < DEPTH_W);
  assign rd_ok       = rd_en && !init_busy;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
  assign coll        = (BYPASS != 0) && wr_ok && (mem_addr == rd_addr);
  assign fwd_be      = coll ? mem_be : '0;

  // Array write: only enabled bytes change; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
`ifdef SDPB_PARITY_EN
          par_mem[mem_addr][i] <= byte_parity(mem_data[8*i +: 8]);
`endif
        end
      end
    end
  end

  // Read word: merges forwarded write bytes over stored bytes and checks parity.
  always_comb begin
    rd_word = '0;
    rd_perr = 1'b0;
    if (rd_in_range) begin
      for (int i = 0; i < NB; i++) begin
        rd_word[8*i +: 8] = merge_byte(mem[rd_addr][8*i +: 8], mem_data[8*i +: 8], fwd_be[i]);
`ifdef SDPB_PARITY_EN
        rd_perr = rd_perr |
                  (~fwd_be[i] & (byte_parity(mem[rd_addr][8*i +: 8]) ^ par_mem[rd_addr][i]));
`endif
      end
    end
  end

  logic [DW-1:0] s1_data;
  logic          s1_perr;
  logic          s1_fresh;
  logic          consume;

  // In the 1-cycle build every edge consumes stage 1; otherwise rd_oce does.
  assign consume = (READ_LAT == READ_LAT_2) ? rd_oce : 1'b1;

  // Stage 1: capture the array word; fresh marks a word not yet presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_perr  <= 1'b0;
      s1_fresh <= 1'b0;
    end else begin
      if (rd_ok) begin
        s1_data <= rd_word;
        s1_perr <= rd_perr;
      end
      if (rd_ok)                      s1_fresh <= 1'b1;
      else if (consume || init_busy)  s1_fresh <= 1'b0;
    end
  end

  generate
    if (READ_LAT == READ_LAT_2) begin : g_lat2
      logic [DW-1:0] s2_data;
      logic          s2_perr;
      logic          s2_vld;

      // Stage 2: output register gated by rd_oce; valid only for a new word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data <= '0;
          s2_perr <= 1'b0;
          s2_vld  <= 1'b0;
        end else begin
          if (rd_oce) begin
            s2_data <= s1_data;
            s2_perr <= s1_perr;
          end
          s2_vld <= rd_oce && s1_fresh && !init_busy;
        end
      end

      assign rd_data    = s2_data;
      assign rd_par_err = s2_perr;
      assign rd_valid   = s2_vld;
    end else begin : g_lat1
      assign rd_data    = s1_data;
      assign rd_par_err = s1_perr;
      assign rd_valid   = s1_fresh;
    end
  endgenerate

endmodule

// File: tb/tb_sdpb_ram_ctrl.sv
// Directed bench: instance A (DEPTH=16, 1-cycle read, write-through, manual clear)
// and instance B (DEPTH=12, 2-cycle read, read-old-data, clear after reset).
module tb_sdpb_ram_ctrl;

  logic clk;
  logic rst_n;

  logic        a_wr_en, a_rd_en, a_rd_oce, a_init_req;
  logic [3:0]  a_wr_addr, a_rd_addr;
  logic [15:0] a_wr_data, a_rd_data;
  logic [1:0]  a_wr_be;
  logic        a_rd_valid, a_rd_par_err, a_init_busy;

  logic        b_wr_en, b_rd_en, b_rd_oce, b_init_req;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic [15:0] b_wr_data, b_rd_data;
  logic [1:0]  b_wr_be;
  logic        b_rd_valid, b_rd_par_err, b_init_busy;

  int checks = 0;
  int errors = 0;
  int n;

  sdpb_ram_ctrl #(
    .DW(16), .DEPTH(16), .READ_LAT(1), .BYPASS(1),
    .INIT_ON_RESET(0), .INIT_VALUE(16'hDEAD)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_oce(a_rd_oce),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_par_err(a_rd_par_err),
    .init_req(a_init_req), .init_busy(a_init_busy)
  );

  sdpb_ram_ctrl #(
    .DW(16), .DEPTH(12), .READ_LAT(2), .BYPASS(0),
    .INIT_ON_RESET(1), .INIT_VALUE(16'h3C3C)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_oce(b_rd_oce),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_par_err(b_rd_par_err),
    .init_req(b_init_req), .init_busy(b_init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_wr_en = 0; a_rd_en = 0; a_rd_oce = 1; a_init_req = 0;
    a_wr_addr = 0; a_rd_addr = 0; a_wr_data = 0; a_wr_be = 0;
    b_wr_en = 0; b_rd_en = 0; b_rd_oce = 1; b_init_req = 0;
    b_wr_addr = 0; b_rd_addr = 0; b_wr_data = 0; b_wr_be = 0;

    // Reset state
    tick(); tick();
    check("rst_a_data",  32'(a_rd_data), 32'h0);
    check("rst_a_valid", 32'(a_rd_valid), 32'h0);
    check("rst_a_perr",  32'(a_rd_par_err), 32'h0);
    check("rst_a_busy",  32'(a_init_busy), 32'h0);
    check("rst_b_busy",  32'(b_init_busy), 32'h1);
    check("rst_b_data",  32'(b_rd_data), 32'h0);
    rst_n = 1'b1;

    // B clears itself after reset: 12 busy cycles
    n = 0;
    while (b_init_busy && n < 100) begin
      tick();
      n++;
    end
    check("b_reset_clear_len", 32'(n), 32'd12);

    // Full write then 1-cycle read
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 16'hA5C3; a_wr_be = 2'b11; tick();
    a_wr_en = 0; a_rd_en = 1; a_rd_addr = 5; tick();
    check("t1_data",  32'(a_rd_data), 32'hA5C3);
    check("t1_valid", 32'(a_rd_valid), 32'h1);
    a_rd_en = 0; tick();
    check("t1_valid_drop", 32'(a_rd_valid), 32'h0);
    check("t1_data_hold",  32'(a_rd_data), 32'hA5C3);

    // wr_be=0 leaves the word untouched
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 16'h0000; a_wr_be = 2'b00; tick();
    a_wr_en = 0; a_rd_en = 1; a_rd_addr = 5; tick();
    check("be0_data", 32'(a_rd_data), 32'hA5C3);
    a_rd_en = 0;

    // Partial byte write
    a_wr_en = 1; a_wr_addr = 7; a_wr_data = 16'hFFFF; a_wr_be = 2'b11; tick();
    a_wr_data = 16'h1234; a_wr_be = 2'b01; tick();
    a_wr_en = 0; a_rd_en = 1; a_rd_addr = 7; tick();
    check("t2_merge", 32'(a_rd_data), 32'hFF34);
    a_rd_en = 0;

    // Same-edge collision on addr 3 (A forwards, B returns old)
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 16'h0011; a_wr_be = 2'b11;
    b_wr_en = 1; b_wr_addr = 3; b_wr_data = 16'h0011; b_wr_be = 2'b11;
    tick();
    a_wr_data = 16'hBEEF; a_wr_be = 2'b10; a_rd_en = 1; a_rd_addr = 3;
    b_wr_data = 16'hBEEF; b_wr_be = 2'b10; b_rd_en = 1; b_rd_addr = 3;
    tick();
    check("coll_bypass_data",  32'(a_rd_data), 32'hBE11);
    check("coll_bypass_valid", 32'(a_rd_valid), 32'h1);
    check("coll_b_not_yet",    32'(b_rd_valid), 32'h0);
    a_wr_en = 0; a_rd_en = 0; b_wr_en = 0; b_rd_en = 0;
    tick();
    check("coll_old_data",  32'(b_rd_data), 32'h0011);
    check("coll_old_valid", 32'(b_rd_valid), 32'h1);

    // B contents from the reset clear
    b_rd_en = 1; b_rd_addr = 1; tick();
    b_rd_en = 0; tick();
    check("b_init_data",  32'(b_rd_data), 32'h3C3C);
    check("b_init_valid", 32'(b_rd_valid), 32'h1);

    // Output-register enable: held low for 3 edges
    b_wr_en = 1; b_wr_addr = 9; b_wr_data = 16'h5555; b_wr_be = 2'b11; tick();
    b_wr_en = 0; b_rd_oce = 0; b_rd_en = 1; b_rd_addr = 9; tick();
    b_rd_en = 0;
    check("oce_hold1", 32'(b_rd_data), 32'h3C3C);
    check("oce_vld1",  32'(b_rd_valid), 32'h0);
    tick();
    check("oce_hold2", 32'(b_rd_data), 32'h3C3C);
    tick();
    check("oce_hold3", 32'(b_rd_data), 32'h3C3C);
    check("oce_vld3",  32'(b_rd_valid), 32'h0);
    b_rd_oce = 1; tick();
    check("oce_load_data",  32'(b_rd_data), 32'h5555);
    check("oce_load_valid", 32'(b_rd_valid), 32'h1);
    tick();
    check("oce_single_pulse", 32'(b_rd_valid), 32'h0);
    check("oce_data_stays",   32'(b_rd_data), 32'h5555);

    // Out-of-range on non-power-of-2 depth: write dropped, read gives 0 valid
    b_wr_en = 1; b_wr_addr = 13; b_wr_data = 16'h7777; b_wr_be = 2'b11;
    b_rd_en = 1; b_rd_addr = 13; tick();
    b_wr_en = 0; b_rd_en = 0; tick();
    check("oor_data",  32'(b_rd_data), 32'h0);
    check("oor_valid", 32'(b_rd_valid), 32'h1);

    // Manual clear on A: 16 busy cycles, late user write dropped, reads ignored
    a_init_req = 1; tick();
    a_init_req = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_init_busy) n++;
      if (i == 0) begin
        a_rd_en = 1; a_rd_addr = 5;
      end
      if (i == 1) begin
        check("clear_rd_ignored", 32'(a_rd_valid), 32'h0);
        a_rd_en = 0;
      end
      if (i == 14) begin
        a_wr_en = 1; a_wr_addr = 2; a_wr_data = 16'h2222; a_wr_be = 2'b11;
      end
      if (i == 15) a_wr_en = 0;
      tick();
    end
    check("clear_busy_len", 32'(n), 32'd16);

    for (int i = 0; i < 16; i++) begin
      a_rd_en = 1; a_rd_addr = 4'(i); tick();
      check($sformatf("clear_rd_addr%0d", i), 32'(a_rd_data), 32'hDEAD);
    end
    a_rd_en = 0;

`ifdef SDPB_PARITY_EN
    dut_a.par_mem[4][0] <= ~dut_a.par_mem[4][0];
    #1;
    a_rd_en = 1; a_rd_addr = 4; tick();
    check("par_err_data", 32'(a_rd_data), 32'hDEAD);
    check("par_err_flag", 32'(a_rd_par_err), 32'h1);
    a_rd_addr = 5; tick();
    check("par_ok_flag", 32'(a_rd_par_err), 32'h0);
    a_rd_en = 0;
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
